uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver (8N1 default), the RX end of the UART link.
//  Recovers bytes from rx_i and presents them on a valid/ready output port.
//  Keeps its own bit-timing counter, restarted on each start edge. The free-running
//  baud ticks are not used, so the mid-bit sample point aligns to the incoming frame.
//  Sits between the pad and the loopback/host byte sink.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency, Hz
//  BAUD       115200      line rate, bit/s; DIV = CLK_HZ/BAUD (integer divide), HALF = DIV/2
//  DATA_BITS  8           data bits per frame, LSB first; 1 start, 1 stop, no parity
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          reset, asynchronous, active-low
//  rx_i         in   1          serial line, asynchronous to clk, idle high
//  data_o       out  DATA_BITS  received word; stable while valid_o=1
//  valid_o      out  1          word available; held until ready_i
//  ready_i      in   1          sink accepts; transfer when valid_o & ready_i
//  frame_err_o  out  1          1-cycle pulse: stop bit sampled low
//  overrun_o    out  1          1-cycle pulse: new word dropped, output still occupied
//  busy_o       out  1          1 in any state other than IDLE
// BEHAVIOUR
//  - Reset values: data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
//    Synchronizer flops reset to 1; FSM to IDLE; counter and bit index to 0.
//  - rx_i passes through a 2-flop synchronizer. All decisions use the synced value rxs.
//  - Elaboration assertion: DIV >= 4.
//  - FSM states: IDLE, START, DATA, STOP, WAIT_HI.
//    IDLE: rxs==0 -> START with cnt=0.
//    START: cnt counts up each clk. At cnt==HALF-1, sample rxs:
//      rxs=1 -> IDLE (glitch rejected, no flags);
//      rxs=0 -> DATA with cnt=0, idx=0.
//    DATA: at cnt==DIV-1, shift rxs into bit idx (LSB first), cnt=0, idx++.
//      After bit DATA_BITS-1 -> STOP.
//    STOP: at cnt==DIV-1, sample rxs:
//      rxs=1 -> deliver word, go to IDLE (next start edge is accepted right away);
//      rxs=0 -> frame_err_o pulse, discard word, go to WAIT_HI.
//    WAIT_HI: stay until rxs==1, then IDLE. A break is never taken as a start bit.
//  - Delivery (cycle after the stop sample):
//      valid_o=0 -> load data_o, set valid_o=1.
//      valid_o=1 & ready_i=1 -> old word transfers, new word loaded, valid_o stays 1, no overrun.
//      valid_o=1 & ready_i=0 -> overrun_o pulse, new word dropped, data_o unchanged.
//  - Handshake: valid_o falls the cycle after valid_o&ready_i when no delivery coincides.
//    data_o never changes while valid_o=1 and ready_i=0.
//  - Latency: falling edge on rx_i -> valid_o = 2 (sync) + 1 (detect) + HALF
//    + (DATA_BITS+1)*DIV + 1 clk, +/-1 clk for edge phase.
//  - rst_n asserted mid-frame: everything returns to reset values at once; the partial word is lost.
//    After release, a line held low is seen as a start in IDLE. Frame sync is regained on the next
//    good frame (WAIT_HI not entered from reset).
//  - Counter width: $clog2(DIV). Bit index width: $clog2(DATA_BITS+1).
//    Counter cleared on every state change.
// STRUCTURE
//  - uart_pkg: typedef enum logic [2:0] rx_state_t {IDLE,START,DATA,STOP,WAIT_HI};
//    function uart_div(clk_hz, baud); UART_IDLE_LVL = 1'b1. Shared with uart_tx.
//  - Sub-module uart_sync2: 2-flop synchronizer, reset value parameterised (1 here).
//  - uart_rx: FSM + counter + shifter + output register in this file.
// TESTING (CLK_HZ=16, BAUD=1 -> DIV=16, HALF=8, DATA_BITS=8)
//  1. Drive 0xA5 frame, ready_i=1
//     -> valid_o=1 for 1 clk, data_o=8'hA5, no flags; falling-edge-to-valid in 2+1+8+144+1 +/-1 clk.
//  2. rx_i low for 4 clk, then high
//     -> back to IDLE at the HALF sample, busy_o drops, no valid_o, no frame_err_o.
//  3. Frame 0x3C with stop bit low, then 40 clk low, then high
//     -> frame_err_o pulse, no valid_o, busy_o=1 until line high, then next 0x55 received OK.
//  4. ready_i=0, send 0x11 then 0x22
//     -> valid_o=1, data_o=8'h11 held, overrun_o pulse at 0x22 delivery.
//     Then ready_i=1 -> valid_o drops next clk.
//  5. ready_i pulsed in the same cycle 0x22 delivers, over held 0x11
//     -> no overrun_o, data_o=8'h22, valid_o stays 1.
//  6. rst_n low mid-DATA of 0xFF, release, send 0x81
//     -> all outputs 0 during reset, then data_o=8'h81 valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and the
// baud divider helper used by both ends of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level; the reset value is
// chosen so the synchronized line comes out of reset at its idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame-aligned bit timing, LSB-first shifter and a one-word
// valid/ready output register with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // The mid-start sample needs at least a couple of cycles on either side.
  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  logic                 rxs;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic                 frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  uart_sync2 #(
    .RESET_VAL(UART_IDLE_LVL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_i),
    .q_o  (rxs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Data bits shift in from the top so the first (LSB) bit ends up in bit 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          deliver_d   = rxs;
          frame_err_d = !rxs;
          state_d     = rxs ? IDLE : WAIT_HI;
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A delivery meeting an accepted word replaces it in place; otherwise a
  // still-occupied output drops the new word and flags the overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (deliver_q) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: a scoreboard queue of expected
// words is filled as frames are driven and drained by a monitor on each transfer.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] sbQ[$];

  int validRise = 0;
  int validCycles = 0;
  int frameErrCnt = 0;
  int overrunCnt = 0;
  int riseCyc = 0;
  logic prevValid = 1'b0;
  logic prevReady = 1'b0;
  logic [7:0] prevData = 8'h00;

  int c0, v0, r0, f0, o0, lat;

  uart_rx #(
    .CLK_HZ   (16),
    .BAUD     (1),
    .DATA_BITS(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame, 16 clocks per bit; the line is left at the stop level.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input bit push);
    if (push) sbQ.push_back(b);
    rx_i = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(16);
    end
    rx_i = stopBit;
    tick(16);
  endtask

  // Monitor samples mid-cycle, seeing exactly what the DUT sees at the next edge.
  always @(negedge clk) begin
    if (valid_o && !prevValid) begin
      validRise++;
      riseCyc = cyc;
    end
    if (valid_o) validCycles++;
    if (frame_err_o) frameErrCnt++;
    if (overrun_o) overrunCnt++;
    if (prevValid && !prevReady && valid_o) checkOutput("hold_stable", data_o, prevData);
    if (valid_o && ready_i) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_underflow", sbQ.size(), 1);
      end else begin
        checkOutput("sb_data", data_o, sbQ.pop_front());
      end
    end
    prevValid = valid_o;
    prevReady = ready_i;
    prevData  = data_o;
  end

  initial begin
    rst_n   = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b1;
    tick(3);
    checkOutput("reset_data", data_o, 8'h00);
    checkOutput("reset_valid", valid_o, 1'b0);
    checkOutput("reset_frame_err", frame_err_o, 1'b0);
    checkOutput("reset_overrun", overrun_o, 1'b0);
    checkOutput("reset_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    tick(5);

    $display("[TB] step 1: 0xA5 with ready high");
    c0 = cyc; v0 = validCycles; f0 = frameErrCnt; o0 = overrunCnt;
    applyStimulus(8'hA5, 1'b1, 1'b1);
    tick(10);
    lat = riseCyc - c0;
    checkOutput("latency_window", (lat >= 155 && lat <= 157) ? 1 : 0, 1);
    checkOutput("valid_one_cycle", validCycles - v0, 1);
    checkOutput("no_frame_err_1", frameErrCnt - f0, 0);
    checkOutput("no_overrun_1", overrunCnt - o0, 0);
    checkOutput("sb_empty_1", sbQ.size(), 0);

    $display("[TB] step 2: short glitch");
    r0 = validRise; f0 = frameErrCnt;
    rx_i = 1'b0;
    tick(4);
    checkOutput("glitch_busy", busy_o, 1'b1);
    rx_i = 1'b1;
    tick(12);
    checkOutput("glitch_idle", busy_o, 1'b0);
    checkOutput("glitch_no_valid", validRise - r0, 0);
    checkOutput("glitch_no_frame_err", frameErrCnt - f0, 0);

    $display("[TB] step 3: framing error and break");
    r0 = validRise; f0 = frameErrCnt;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    tick(40);
    checkOutput("frame_err_pulse", frameErrCnt - f0, 1);
    checkOutput("break_busy", busy_o, 1'b1);
    checkOutput("frame_err_no_valid", validRise - r0, 0);
    rx_i = 1'b1;
    tick(6);
    checkOutput("break_released", busy_o, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b1);
    tick(5);
    checkOutput("sb_empty_3", sbQ.size(), 0);
    checkOutput("recover_valid", validRise - r0, 1);

    $display("[TB] step 4: overrun with ready low");
    ready_i = 1'b0;
    o0 = overrunCnt;
    applyStimulus(8'h11, 1'b1, 1'b1);
    applyStimulus(8'h22, 1'b1, 1'b0);
    tick(4);
    checkOutput("overrun_valid", valid_o, 1'b1);
    checkOutput("overrun_data_held", data_o, 8'h11);
    checkOutput("overrun_pulse", overrunCnt - o0, 1);
    ready_i = 1'b1;
    tick(1);
    checkOutput("valid_drop", valid_o, 1'b0);
    checkOutput("sb_empty_4", sbQ.size(), 0);

    $display("[TB] step 5: accept coincides with delivery");
    ready_i = 1'b0;
    o0 = overrunCnt; r0 = validRise;
    applyStimulus(8'h11, 1'b1, 1'b1);
    fork
      applyStimulus(8'h22, 1'b1, 1'b1);
      begin
        tick(155);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
      end
    join
    tick(3);
    checkOutput("swap_no_overrun", overrunCnt - o0, 0);
    checkOutput("swap_valid", valid_o, 1'b1);
    checkOutput("swap_data", data_o, 8'h22);
    checkOutput("swap_valid_continuous", validRise - r0, 1);
    checkOutput("swap_sb_pending", sbQ.size(), 1);
    ready_i = 1'b1;
    tick(2);
    checkOutput("swap_drain", valid_o, 1'b0);

    $display("[TB] step 6: reset mid-frame");
    fork
      applyStimulus(8'hFF, 1'b1, 1'b0);
      begin
        tick(60);
        checkOutput("mid_frame_busy", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_data", data_o, 8'h00);
        checkOutput("rst_valid", valid_o, 1'b0);
        checkOutput("rst_frame_err", frame_err_o, 1'b0);
        checkOutput("rst_overrun", overrun_o, 1'b0);
        checkOutput("rst_busy", busy_o, 1'b0);
        tick(3);
        rst_n = 1'b1;
      end
    join
    tick(5);
    r0 = validRise;
    applyStimulus(8'h81, 1'b1, 1'b1);
    tick(5);
    checkOutput("post_reset_valid", validRise - r0, 1);
    checkOutput("sb_empty_final", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
